mulu_x2y2_arb: RTL

MULU_X2Y2_ARB -- requirements
Module: mulu_x2y2_arb

---
 rtl/mulu_x2y2_arb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mulu_x2y2_arb.sv
// Two-requester front end for a shared mulu_x2y2 multiplier.
// A request is granted and its operands are registered toward the multiplier.
// The product is captured SETTLE cycles later and held until the granted
// requester takes it. Ties alternate between the requesters.
module mulu_x2y2_arb #(
  parameter int X_WIDTH = 2,
  parameter int Y_WIDTH = 2,
  parameter int P_WIDTH = X_WIDTH + Y_WIDTH,
  parameter int SETTLE  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic               req1_valid,
  input  logic [X_WIDTH-1:0] req0_x,
  input  logic [X_WIDTH-1:0] req1_x,
  input  logic [Y_WIDTH-1:0] req0_y,
  input  logic [Y_WIDTH-1:0] req1_y,
  output logic               req0_ready,
  output logic               req1_ready,
  output logic [X_WIDTH-1:0] mul_x,
  output logic [Y_WIDTH-1:0] mul_y,
  input  logic [P_WIDTH-1:0] mul_p,
  output logic               rsp0_valid,
  output logic               rsp1_valid,
  input  logic               rsp0_ready,
  input  logic               rsp1_ready,
  output logic [P_WIDTH-1:0] rsp_p,
  output logic               busy,
  output logic [7:0]         op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_last_grant;
  logic               r_grant;
  logic [2:0]         r_cnt;
  logic [X_WIDTH-1:0] r_mul_x;
  logic [Y_WIDTH-1:0] r_mul_y;
  logic [P_WIDTH-1:0] r_rsp_p;
  logic [7:0]         r_op_count;
  logic               w_grant;
  logic               w_accept;
  logic               w_done;

  assign mul_x    = r_mul_x;
  assign mul_y    = r_mul_y;
  assign rsp_p    = r_rsp_p;
  assign op_count = r_op_count;
  assign busy     = !reset && (r_state != IDLE);

  // Arbitration, handshakes and next-state selection; everything is masked while reset is high
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    // On a tie the requester that did not win last time gets the grant
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = req1_valid;
    end
    if (!reset) begin
      case (r_state)
        IDLE: begin
          req0_ready = req0_valid && !w_grant;
          req1_ready = req1_valid && w_grant;
          w_accept   = (req0_valid && !w_grant) || (req1_valid && w_grant);
          if (w_accept) begin
            w_state_next = WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 3'd1) begin
            w_state_next = RESP;
          end
        end
        RESP: begin
          rsp0_valid = !r_grant;
          rsp1_valid = r_grant;
          w_done     = r_grant ? rsp1_ready : rsp0_ready;
          if (w_done) begin
            w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand capture on accept; operands stay put until the next accept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mul_x <= '0;
      r_mul_y <= '0;
      r_grant <= 1'b0;
    end else if (w_accept) begin
      r_mul_x <= w_grant ? req1_x : req0_x;
      r_mul_y <= w_grant ? req1_y : req0_y;
      r_grant <= w_grant;
    end
  end

  // Settle countdown; the product is sampled on the last counting edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= 3'd0;
      r_rsp_p <= '0;
    end else if (w_accept) begin
      r_cnt <= 3'(SETTLE);
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - 3'd1;
      if (r_cnt == 3'd1) begin
        r_rsp_p <= mul_p;
      end
    end
  end

  // Completion bookkeeping: remember the winner for tie-breaks and count the operation
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_op_count   <= 8'd0;
    end else if (w_done) begin
      r_last_grant <= r_grant;
      r_op_count   <= r_op_count + 8'd1;
    end
  end

endmodule
